amf_frame_sched: RTL

Frame scheduler sitting between the host frame loader and the adaptive median filter (`amf`). It manages a ping-pong pair of input SRAM banks. The host fills one bank while the filter processes the other. The block accepts frame descriptors (M×N) over a req/ack handshake, launches the filter with `filterEn`/`M`/`N`, and retires each frame on `filterF`. It also reports a completion pulse and a frame count.

---
 rtl/amf_frame_sched.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/amf_frame_sched.sv
// amf_frame_sched: ping-pong bank scheduler in front of the adaptive median filter.
// Host descriptors {M,N} land in one slot per bank; the FSM launches the filter on
// the processing bank and retires it on the filterF rising edge.
// Optional feature macro: AMF_SCHED_WDT_EN (RUN-state watchdog, sets wdtErr).
module amf_frame_sched #(
  parameter int DIM_WIDTH  = 16,
  parameter int CNT_WIDTH  = 8,
  parameter int WDT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frameRdy,
  input  logic [DIM_WIDTH-1:0] frameM,
  input  logic [DIM_WIDTH-1:0] frameN,
  output logic                 frameAck,
  output logic                 bankFill,
  output logic                 filterEn,
  output logic [DIM_WIDTH-1:0] M,
  output logic [DIM_WIDTH-1:0] N,
  input  logic                 filterF,
  output logic                 bankProc,
  output logic                 resValid,
  output logic                 resBank,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] frameCnt,
  output logic [CNT_WIDTH-1:0] dropCnt,
  output logic                 wdtErr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]           state;
  logic [1:0]           occ;
  logic [1:0]           occNext;
  logic [DIM_WIDTH-1:0] slotM [2];
  logic [DIM_WIDTH-1:0] slotN [2];
  logic                 filterFQ;
  logic                 launchWait;
  logic                 timeout;
  logic                 req, zeroSize, alloc, drop, free, rise, tgt;
  logic [DIM_WIDTH-1:0] nextM, nextN;

  // Handshake qualification, occupancy update and next-descriptor selection
  always_comb begin
    req      = frameRdy && !frameAck;
    zeroSize = (frameM == '0) || (frameN == '0);
    drop     = req && zeroSize;
    free     = (state == DONE);
    // at occupancy 2 a retiring frame frees its slot in the same cycle
    alloc    = req && !zeroSize && ((occ != 2'd2) || free);
    rise     = filterF && !filterFQ;
    occNext  = occ + {1'b0, alloc} - {1'b0, free};
    // DONE launches the other bank; IDLE launches the current one
    tgt      = free ? ~bankProc : bankProc;
    // bypass: a descriptor written this cycle into the bank about to launch
    if (alloc && (bankFill == tgt)) begin
      nextM = frameM;
      nextN = frameN;
    end else begin
      nextM = slotM[tgt];
      nextN = slotN[tgt];
    end
  end

  assign filterEn = (state == RUN);
  assign busy     = (occ != 2'd0) || (state != IDLE);
  assign resBank  = bankProc;

  // Accept path: slot write, ack pulse, fill-bank toggle, drop counting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frameAck <= 1'b0;
      bankFill <= 1'b0;
      occ      <= 2'd0;
      dropCnt  <= '0;
      slotM[0] <= '0;
      slotM[1] <= '0;
      slotN[0] <= '0;
      slotN[1] <= '0;
    end else begin
      frameAck <= alloc || drop;
      occ      <= occNext;
      if (alloc) begin
        slotM[bankFill] <= frameM;
        slotN[bankFill] <= frameN;
        bankFill        <= ~bankFill;
      end
      if (drop) dropCnt <= dropCnt + CNT_WIDTH'(1);
    end
  end

  // Frame FSM: M/N load on LAUNCH entry, one settle cycle, then run until retire
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      launchWait <= 1'b0;
      bankProc   <= 1'b0;
      M          <= '0;
      N          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (occ != 2'd0) begin
            state      <= LAUNCH;
            launchWait <= 1'b1;
            M          <= nextM;
            N          <= nextN;
          end
        end
        LAUNCH: begin
          if (launchWait)    launchWait <= 1'b0;
          else if (!filterF) state      <= RUN;
        end
        RUN: begin
          if (rise || timeout) state <= DONE;
        end
        default: begin
          bankProc <= ~bankProc;
          if (occNext != 2'd0) begin
            state      <= LAUNCH;
            launchWait <= 1'b1;
            M          <= nextM;
            N          <= nextN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Retire reporting: filterF edge history, result pulse and frame counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filterFQ <= 1'b0;
      resValid <= 1'b0;
      frameCnt <= '0;
    end else begin
      filterFQ <= filterF;
      resValid <= (state == RUN) && rise;
      if ((state == RUN) && rise) frameCnt <= frameCnt + CNT_WIDTH'(1);
    end
  end

`ifdef AMF_SCHED_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  logic [WW-1:0] wdtCnt;

  // a genuine filterF edge always wins over an expiring watchdog
  assign timeout = (wdtCnt == WW'(WDT_CYCLES - 1)) && !rise;

  // Watchdog: count RUN cycles, flag a frame that never finishes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdtCnt <= '0;
      wdtErr <= 1'b0;
    end else begin
      wdtCnt <= (state == RUN) ? wdtCnt + WW'(1) : '0;
      if ((state == RUN) && timeout) wdtErr <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign wdtErr  = 1'b0;
`endif

endmodule
